// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage feeding the IF/ID pipeline register. It owns the
//   PC and keeps at most one req/ack transaction open to instruction memory.
//   Once a word has been fetched, it is presented as {if_pc, if_inst}. While a
//   fetch is still in flight, both outputs are zero (a bubble) and
//   stallreq_if is raised. The unit obeys stall[0], an exception flush, and
//   ID-stage branch redirects. Branches have one MIPS delay slot.
//
// Ports
//   clk, resetn        clock (rising edge); asynchronous active-low reset
//   stall[5:0]         pipeline stall vector; bit0 = PC/IF, bit2 = ID
//   flush, new_pc      exception flush and its redirect target
//   branch_flag,
//   branch_target      taken branch/jump resolved in ID, and its target
//   inst_req,
//   inst_addr          fetch request; the address is held until inst_ack
//   inst_ack,
//   inst_rdata         one-cycle acknowledge carrying the fetched word
//   if_pc, if_inst     presented instruction; both zero when none
//   stallreq_if        high while no instruction is presented
//
// Every output is decoded from registered state only.
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  // FETCH : a request is open at addr_q.
  // READY : inst_buf_q is presented for the instruction at pc_q.
  // DRAIN : an abandoned request is still open at the old address. Its data
  //         will be thrown away; pc_q already holds the flush target.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READY = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        br_pend_q,  br_pend_d;
  logic [31:0] br_tgt_q,   br_tgt_d;

  logic [31:0] next_pc;
  logic        advance;
  logic        branch_take;

  // The remaining stall bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^{stall[5:3], stall[1]};

  assign branch_take = branch_flag && !stall[2];

  // A branch captured earlier takes priority: the instruction it skips past
  // (the delay slot) is the one that has just been presented.
  assign next_pc = br_pend_q   ? br_tgt_q      :
                   branch_take ? branch_target :
                                 pc_q + 32'd4;

  always_comb begin
    // NOTE: every signal assigned here is given a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    br_pend_d  = br_pend_q;
    br_tgt_d   = br_tgt_q;
    advance    = 1'b0;

    if (flush) begin
      pc_d      = new_pc;
      br_pend_d = 1'b0;
      unique case (state_q)
        // With no ack yet, the open request must still finish at the old
        // address. An ack in the same cycle closes it, and its data is dropped.
        FETCH:   state_d = inst_ack ? FETCH : DRAIN;
        READY:   state_d = FETCH;
        DRAIN:   state_d = inst_ack ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      unique case (state_q)
        FETCH: begin
          if (inst_ack) begin
            inst_buf_d = inst_rdata;
            state_d    = READY;
          end
        end
        READY: begin
          if (!stall[0]) begin
            advance   = 1'b1;
            pc_d      = next_pc;
            br_pend_d = 1'b0;
            state_d   = FETCH;
          end
        end
        DRAIN: begin
          if (inst_ack) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase

      // A redirect that cannot be applied right now waits until the current
      // IF instruction (the delay slot) has been handed on.
      if (!advance && branch_take) begin
        br_pend_d = 1'b1;
        br_tgt_d  = branch_target;
      end
    end

    // In DRAIN the request address is frozen. In every other state, the
    // address follows the PC the next request will use.
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples its pre-edge _d value, whatever order the statements are in.
  // NOTE: inst_buf_q is a single register, not a memory array, so it is reset
  // here with the rest of the state. A reset mid-transaction leaves nothing
  // stale behind.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      inst_buf_q <= '0;
      br_pend_q  <= 1'b0;
      br_tgt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inst_buf_q <= inst_buf_d;
      br_pend_q  <= br_pend_d;
      br_tgt_q   <= br_tgt_d;
    end
  end

  assign inst_req    = (state_q != READY);
  assign inst_addr   = addr_q;
  assign stallreq_if = (state_q != READY);
  assign if_pc       = (state_q == READY) ? pc_q       : 32'd0;
  assign if_inst     = (state_q == READY) ? inst_buf_q : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit. Inputs are driven and outputs are
//   sampled on the falling clock edge.
//
//   Whenever a fetch is acknowledged with data that must reach the ID stage,
//   the expected {pc, inst} pair is pushed onto a scoreboard queue. A monitor
//   pops one entry each time the unit starts presenting an instruction.
//   Data from dropped fetches is never pushed, so any presentation of such
//   data shows up as a mismatch.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .inst_req      (inst_req),
    .inst_addr     (inst_addr),
    .inst_ack      (inst_ack),
    .inst_rdata    (inst_rdata),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .stallreq_if   (stallreq_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } pres_t;

  typedef struct {
    int          lat;    // wait cycles in FETCH before the ack
    logic [31:0] rdata;  // word returned by memory
    int          hold;   // cycles of stall[0] while READY
    logic [31:0] addr;   // expected fetch address
  } vec_t;

  pres_t sb[$];
  int    n_total = 0;
  int    n_pass  = 0;
  logic  prev_stallreq = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard monitor: one pop per new presentation.
  always @(negedge clk) begin
    if (resetn && !stallreq_if && prev_stallreq) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        pres_t e;
        e = sb.pop_front();
        check("sb_if_pc", if_pc, e.pc);
        check("sb_if_inst", if_inst, e.inst);
      end
    end
    prev_stallreq = stallreq_if;
  end

  // Entry is at a falling edge with the DUT in FETCH at exp_addr.
  // Exit is at the falling edge where the DUT is in READY.
  task automatic fetch(input logic [31:0] exp_addr, input int lat, input logic [31:0] data);
    check("fetch_req", inst_req, 1'b1);
    check("fetch_addr", inst_addr, exp_addr);
    check("fetch_bubble", if_inst, 32'd0);
    for (int i = 0; i < lat; i++) tick();
    check("fetch_addr_stable", inst_addr, exp_addr);
    inst_ack   = 1'b1;
    inst_rdata = data;
    sb.push_back('{pc: exp_addr, inst: data});
    tick();
    inst_ack   = 1'b0;
    inst_rdata = 32'h0;
    check("ready_stallreq", stallreq_if, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, inst_req, 1'b1);
    check({tag, "_addr"}, inst_addr, RESET_PC);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check({tag, "_if_inst"}, if_inst, 32'd0);
    check({tag, "_stallreq"}, stallreq_if, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{lat: 3, rdata: 32'h2408_0001, hold: 0, addr: 32'hBFC0_0000};
    vecs[1] = '{lat: 0, rdata: 32'h2409_0002, hold: 4, addr: 32'hBFC0_0004};
    vecs[2] = '{lat: 1, rdata: 32'h8C0A_0010, hold: 0, addr: 32'hBFC0_0008};
    vecs[3] = '{lat: 2, rdata: 32'hAC0B_0020, hold: 1, addr: 32'hBFC0_000C};

    resetn = 1'b0; stall = '0; flush = 1'b0; new_pc = '0;
    branch_flag = 1'b0; branch_target = '0; inst_ack = 1'b0; inst_rdata = '0;
    tick(); tick();
    check_reset_outputs("reset");
    resetn = 1'b1;
    tick();
    check_reset_outputs("post_reset");

    // Straight-line fetches, including stall[0] holds in READY. Acks that
    // arrive during a hold must be ignored.
    foreach (vecs[k]) begin
      fetch(vecs[k].addr, vecs[k].lat, vecs[k].rdata);
      if (vecs[k].hold > 0) begin
        stall[0] = 1'b1;
        for (int h = 0; h < vecs[k].hold; h++) begin
          inst_ack   = 1'b1;
          inst_rdata = ~vecs[k].rdata;
          tick();
          check("hold_if_pc", if_pc, vecs[k].addr);
          check("hold_if_inst", if_inst, vecs[k].rdata);
          check("hold_req", inst_req, 1'b0);
        end
        inst_ack = 1'b0;
        stall[0] = 1'b0;
      end
      tick();
    end

    // Branch at 0x10, then its delay slot at 0x14. The redirect is taken
    // while the delay slot is still fetching.
    fetch(32'hBFC0_0010, 0, 32'h1000_0040);
    tick();
    branch_flag = 1'b1; branch_target = 32'h8000_0100;
    tick();
    branch_flag = 1'b0;
    fetch(32'hBFC0_0014, 1, 32'h0000_0000);
    tick();
    check("branch_redirect_addr", inst_addr, 32'h8000_0100);
    fetch(32'h8000_0100, 0, 32'h0800_0080);
    // Branch seen in READY while advancing: applied immediately.
    branch_flag = 1'b1; branch_target = 32'h8000_0200;
    tick();
    branch_flag = 1'b0;
    check("branch_ready_addr", inst_addr, 32'h8000_0200);
    // Branch while ID is stalled must be ignored.
    branch_flag = 1'b1; branch_target = 32'hDEAD_0000; stall[2] = 1'b1;
    tick();
    branch_flag = 1'b0; stall[2] = 1'b0;
    fetch(32'h8000_0200, 0, 32'h3C01_1234);
    tick();
    fetch(32'h8000_0204, 0, 32'h3421_5678);
    tick();

    // Flush during FETCH with no ack: DRAIN at the old address, data dropped.
    flush = 1'b1; new_pc = 32'hBFC0_0380;
    tick();
    flush = 1'b0;
    check("drain_req", inst_req, 1'b1);
    check("drain_addr", inst_addr, 32'h8000_0208);
    check("drain_bubble", if_inst, 32'd0);
    tick();
    check("drain_addr_hold", inst_addr, 32'h8000_0208);
    inst_ack = 1'b1; inst_rdata = 32'hBAD0_BAD0;
    tick();
    inst_ack = 1'b0;
    check("after_drain_addr", inst_addr, 32'hBFC0_0380);
    check("after_drain_stallreq", stallreq_if, 1'b1);
    fetch(32'hBFC0_0380, 1, 32'h4000_6800);
    tick();

    // Flush and ack in the same cycle: data dropped, refetch at new_pc.
    flush = 1'b1; new_pc = 32'hBFC0_0380; inst_ack = 1'b1; inst_rdata = 32'hBAD1_BAD1;
    tick();
    flush = 1'b0; inst_ack = 1'b0;
    check("flush_ack_addr", inst_addr, 32'hBFC0_0380);
    check("flush_ack_stallreq", stallreq_if, 1'b1);
    fetch(32'hBFC0_0380, 0, 32'h4000_7000);
    // Flush from READY, with stall[0] held.
    flush = 1'b1; new_pc = 32'hBFC0_0500; stall[0] = 1'b1;
    tick();
    flush = 1'b0; stall[0] = 1'b0;
    check("flush_ready_addr", inst_addr, 32'hBFC0_0500);
    check("flush_ready_if_pc", if_pc, 32'd0);
    // Flush into DRAIN, then flush again inside DRAIN.
    flush = 1'b1; new_pc = 32'hBFC0_0600;
    tick();
    new_pc = 32'hBFC0_0700;
    tick();
    flush = 1'b0;
    check("double_flush_addr", inst_addr, 32'hBFC0_0500);
    inst_ack = 1'b1; inst_rdata = 32'hBAD2_BAD2;
    tick();
    inst_ack = 1'b0;
    check("double_flush_target", inst_addr, 32'hBFC0_0700);

    // PC wrap: pc+4 from 0xFFFF_FFFC gives 0.
    flush = 1'b1; new_pc = 32'hFFFF_FFFC; inst_ack = 1'b1; inst_rdata = 32'hBAD3_BAD3;
    tick();
    flush = 1'b0; inst_ack = 1'b0;
    fetch(32'hFFFF_FFFC, 0, 32'h2000_0001);
    tick();
    check("wrap_addr", inst_addr, 32'h0000_0000);

    // Asynchronous reset in the middle of DRAIN.
    flush = 1'b1; new_pc = 32'hBFC0_0800;
    tick();
    flush = 1'b0;
    check("pre_reset_drain_addr", inst_addr, 32'h0000_0000);
    #2 resetn = 1'b0;
    #1 check_reset_outputs("async_reset");
    tick();
    resetn = 1'b1;
    tick();
    check_reset_outputs("reset_again");
    fetch(RESET_PC, 1, 32'h2408_00FF);
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
